// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: two-core MSI snoop arbiter and shared single-port RAM controller
module coherence_bus_ctrl #(
    parameter int WORD_W = 32,
    parameter int NCPU   = 2
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NCPU-1:0]          iREN,
    input  logic [NCPU*WORD_W-1:0]   iaddr,
    output logic [NCPU-1:0]          iwait,
    output logic [NCPU*WORD_W-1:0]   iload,
    input  logic [NCPU-1:0]          dREN,
    input  logic [NCPU-1:0]          dWEN,
    input  logic [NCPU*WORD_W-1:0]   daddr,
    input  logic [NCPU*WORD_W-1:0]   dstore,
    output logic [NCPU-1:0]          dwait,
    output logic [NCPU*WORD_W-1:0]   dload,
    input  logic [NCPU-1:0]          cctrans,
    input  logic [NCPU-1:0]          ccwrite,
    output logic [NCPU-1:0]          ccwait,
    output logic [NCPU-1:0]          ccinv,
    output logic [NCPU*WORD_W-1:0]   ccsnoopaddr,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [WORD_W-1:0]        ramaddr,
    output logic [WORD_W-1:0]        ramstore,
    input  logic [WORD_W-1:0]        ramload,
    input  logic [1:0]               ramstate
);
    typedef enum logic [3:0] {IDLE, EVICT, IFETCH, SNOOP, C2C1, C2C2, RD, MEMUPD1, MEMUPD2} state_t;
    state_t state;
    logic rr, req, dirty, inv;
    logic [WORD_W-1:0] buf0, buf1;
    logic [WORD_W-2:0] baddr;
    logic [WORD_W-1:0] ia [NCPU];
    logic [WORD_W-1:0] da [NCPU];
    logic [WORD_W-1:0] ds [NCPU];
    logic [WORD_W-1:0] il [NCPU];
    logic [WORD_W-1:0] dl [NCPU];
    logic [WORD_W-1:0] sa [NCPU];
    logic o, acc, w_dwen, w_cct, w_iren;
    for (genvar n = 0; n < NCPU; n++) begin : g_lane
        assign ia[n] = iaddr[n*WORD_W +: WORD_W];
        assign da[n] = daddr[n*WORD_W +: WORD_W];
        assign ds[n] = dstore[n*WORD_W +: WORD_W];
        assign iload[n*WORD_W +: WORD_W] = il[n];
        assign dload[n*WORD_W +: WORD_W] = dl[n];
        assign ccsnoopaddr[n*WORD_W +: WORD_W] = sa[n];
    end
    assign o      = ~req;
    assign acc    = ramstate == 2'b10;
    assign w_dwen = dWEN[rr] ? rr : ~rr;
    assign w_cct  = cctrans[rr] ? rr : ~rr;
    assign w_iren = iREN[rr] ? rr : ~rr;
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            rr    <= 1'b0;
            req   <= 1'b0;
            dirty <= 1'b0;
            inv   <= 1'b0;
            buf0  <= '0;
            buf1  <= '0;
            baddr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|dWEN) begin
                        req   <= w_dwen;
                        state <= EVICT;
                    end else if (|cctrans) begin
                        req   <= w_cct;
                        state <= SNOOP;
                    end else if (|iREN) begin
                        req   <= w_iren;
                        state <= IFETCH;
                    end
                end
                EVICT, IFETCH: begin
                    state <= acc ? IDLE : state;
                    rr    <= acc ? ~req : rr;
                end
                SNOOP: begin
                    dirty <= ccwrite[o];
                    inv   <= ccwrite[req];
                    state <= (cctrans[o] && dREN[req]) ? C2C1 : dREN[req] ? RD : IDLE;
                    rr    <= dREN[req] ? rr : ~req;
                end
                C2C1: begin
                    buf0  <= ds[o];
                    baddr <= {da[req][WORD_W-1:3], da[req][1:0]};
                    state <= C2C2;
                end
                C2C2: begin
                    // a plain read of a Modified block leaves RAM stale, so flush the forwarded copy
                    buf1  <= ds[o];
                    state <= (dirty && !ccwrite[req]) ? MEMUPD1 : IDLE;
                    rr    <= (dirty && !ccwrite[req]) ? rr : ~req;
                end
                RD: begin
                    state <= (acc && da[req][2]) ? IDLE : RD;
                    rr    <= (acc && da[req][2]) ? ~req : rr;
                end
                MEMUPD1: state <= acc ? MEMUPD2 : MEMUPD1;
                MEMUPD2: begin
                    state <= acc ? IDLE : MEMUPD2;
                    rr    <= acc ? ~req : rr;
                end
                default: state <= IDLE;
            endcase
        end
    end
    always_comb begin
        iwait    = '1;
        dwait    = '1;
        ccwait   = '0;
        ccinv    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        il       = '{default: '0};
        dl       = '{default: '0};
        sa       = '{default: '0};
        case (state)
            EVICT: begin
                ramWEN     = 1'b1;
                ramaddr    = da[req];
                ramstore   = ds[req];
                dwait[req] = ~acc;
            end
            IFETCH: begin
                ramREN     = 1'b1;
                ramaddr    = ia[req];
                il[req]    = ramload;
                iwait[req] = ~acc;
            end
            SNOOP: begin
                ccwait[o] = 1'b1;
                ccinv[o]  = ccwrite[req];
                sa[o]     = da[req];
            end
            C2C1, C2C2: begin
                ccwait[o]  = 1'b1;
                ccinv[o]   = inv;
                sa[o]      = da[req];
                dl[req]    = ds[o];
                dwait[req] = 1'b0;
            end
            RD: begin
                ramREN     = 1'b1;
                ramaddr    = da[req];
                dl[req]    = ramload;
                dwait[req] = ~acc;
            end
            MEMUPD1, MEMUPD2: begin
                ramWEN   = 1'b1;
                ramaddr  = {baddr[WORD_W-2:2], state == MEMUPD2, baddr[1:0]};
                ramstore = state == MEMUPD2 ? buf1 : buf0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl: cycle-by-cycle directed vectors plus hand-written RD/reset sequences
module tb_coherence_bus_ctrl;
    localparam logic [1:0]  ACC = 2'b10;
    localparam logic [1:0]  BSY = 2'b01;
    localparam logic [31:0] N   = 32'h0;
    localparam logic [31:0] D   = 32'hDEAD0000;
    localparam logic [63:0] Z   = 64'h0;
    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  iREN, iwait, dREN, dWEN, dwait, cctrans, ccwrite, ccwait, ccinv, ramstate;
    logic [63:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    int          pass = 0;
    int          total = 0;
    typedef struct {
        logic [1:0]  iren, dren, dwen, cct, ccw, rs;
        logic [31:0] ia0, ia1, da0, da1, ds0, ds1, rl;
        logic [1:0]  e_iw, e_dw, e_ccw, e_cci;
        logic        e_rren, e_rwen;
        logic [31:0] e_ra, e_rst;
        logic [63:0] e_sa, e_il, e_dl;
    } vec_t;
    vec_t tv [32];
    coherence_bus_ctrl dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );
    always #5 CLK = ~CLK;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass++;
    endtask
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask
    task automatic clr;
        iREN = 0; dREN = 0; dWEN = 0; cctrans = 0; ccwrite = 0; ramstate = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    endtask
    task automatic apply(input vec_t t);
        iREN = t.iren; dREN = t.dren; dWEN = t.dwen; cctrans = t.cct; ccwrite = t.ccw; ramstate = t.rs;
        iaddr = {t.ia1, t.ia0}; daddr = {t.da1, t.da0}; dstore = {t.ds1, t.ds0}; ramload = t.rl;
    endtask
    task automatic check_row(input int k, input vec_t t);
        chk($sformatf("v%0d_iwait", k), 64'(iwait), 64'(t.e_iw));
        chk($sformatf("v%0d_dwait", k), 64'(dwait), 64'(t.e_dw));
        chk($sformatf("v%0d_ccwait", k), 64'(ccwait), 64'(t.e_ccw));
        chk($sformatf("v%0d_ccinv", k), 64'(ccinv), 64'(t.e_cci));
        chk($sformatf("v%0d_ramREN", k), 64'(ramREN), 64'(t.e_rren));
        chk($sformatf("v%0d_ramWEN", k), 64'(ramWEN), 64'(t.e_rwen));
        chk($sformatf("v%0d_ramaddr", k), 64'(ramaddr), 64'(t.e_ra));
        chk($sformatf("v%0d_ramstore", k), 64'(ramstore), 64'(t.e_rst));
        chk($sformatf("v%0d_snoopaddr", k), ccsnoopaddr, t.e_sa);
        chk($sformatf("v%0d_iload", k), iload, t.e_il);
        chk($sformatf("v%0d_dload", k), dload, t.e_dl);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        // two icache fetches in rr order, then dcache snoop beats pending ifetches
        tv[0]  = '{2'b11,2'b00,2'b00,2'b00,2'b00,ACC,32'h40,32'h80,N,N,N,N,D, 2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,N,N,Z,Z,Z};
        tv[1]  = '{2'b11,2'b00,2'b00,2'b00,2'b00,ACC,32'h40,32'h80,N,N,N,N,32'h11110040, 2'b10,2'b11,2'b00,2'b00,1'b1,1'b0,32'h40,N,Z,64'h0000_0000_1111_0040,Z};
        tv[2]  = '{2'b11,2'b00,2'b00,2'b00,2'b00,ACC,32'h40,32'h80,N,N,N,N,D, 2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,N,N,Z,Z,Z};
        tv[3]  = '{2'b11,2'b00,2'b00,2'b00,2'b00,ACC,32'h40,32'h80,N,N,N,N,32'h22220080, 2'b01,2'b11,2'b00,2'b00,1'b1,1'b0,32'h80,N,Z,64'h2222_0080_0000_0000,Z};
        tv[4]  = '{2'b11,2'b10,2'b00,2'b10,2'b00,ACC,32'h40,32'h80,N,32'h500,N,N,D, 2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,N,N,Z,Z,Z};
        tv[5]  = '{2'b11,2'b10,2'b00,2'b10,2'b00,ACC,32'h40,32'h80,N,32'h500,N,N,D, 2'b11,2'b11,2'b01,2'b00,1'b0,1'b0,N,N,64'h500,Z,Z};
        tv[6]  = '{2'b11,2'b10,2'b00,2'b10,2'b00,ACC,32'h40,32'h80,N,32'h500,N,N,32'h33330500, 2'b11,2'b01,2'b00,2'b00,1'b1,1'b0,32'h500,N,Z,Z,64'h3333_0500_0000_0000};
        tv[7]  = '{2'b11,2'b10,2'b00,2'b10,2'b00,ACC,32'h40,32'h80,N,32'h504,N,N,32'h44440504, 2'b11,2'b01,2'b00,2'b00,1'b1,1'b0,32'h504,N,Z,Z,64'h4444_0504_0000_0000};
        tv[8]  = '{2'b00,2'b00,2'b00,2'b00,2'b00,ACC,N,N,N,N,N,N,D, 2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,N,N,Z,Z,Z};
        // read miss hitting a dirty block in CPU1: forward then write back
        tv[9]  = '{2'b00,2'b01,2'b00,2'b01,2'b00,ACC,N,N,32'h100,N,N,N,D, 2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,N,N,Z,Z,Z};
        tv[10] = '{2'b00,2'b01,2'b00,2'b11,2'b10,ACC,N,N,32'h100,N,N,32'hAAAA,D, 2'b11,2'b11,2'b10,2'b00,1'b0,1'b0,N,N,64'h0000_0100_0000_0000,Z,Z};
        tv[11] = '{2'b00,2'b01,2'b00,2'b11,2'b10,ACC,N,N,32'h100,N,N,32'hAAAA,D, 2'b11,2'b10,2'b10,2'b00,1'b0,1'b0,N,N,64'h0000_0100_0000_0000,Z,64'h0000_0000_0000_AAAA};
        tv[12] = '{2'b00,2'b01,2'b00,2'b11,2'b10,ACC,N,N,32'h100,N,N,32'hBBBB,D, 2'b11,2'b10,2'b10,2'b00,1'b0,1'b0,N,N,64'h0000_0100_0000_0000,Z,64'h0000_0000_0000_BBBB};
        tv[13] = '{2'b00,2'b00,2'b00,2'b00,2'b00,BSY,N,N,N,N,N,N,D, 2'b11,2'b11,2'b00,2'b00,1'b0,1'b1,32'h100,32'hAAAA,Z,Z,Z};
        tv[14] = '{2'b00,2'b00,2'b00,2'b00,2'b00,ACC,N,N,N,N,N,N,D, 2'b11,2'b11,2'b00,2'b00,1'b0,1'b1,32'h100,32'hAAAA,Z,Z,Z};
        tv[15] = '{2'b00,2'b00,2'b00,2'b00,2'b00,ACC,N,N,N,N,N,N,D, 2'b11,2'b11,2'b00,2'b00,1'b0,1'b1,32'h104,32'hBBBB,Z,Z,Z};
        // write miss against a clean copy: invalidate, forward, no writeback
        tv[16] = '{2'b00,2'b01,2'b00,2'b01,2'b01,ACC,N,N,32'h200,N,N,N,D, 2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,N,N,Z,Z,Z};
        tv[17] = '{2'b00,2'b01,2'b00,2'b11,2'b01,ACC,N,N,32'h200,N,N,32'hCCCC,D, 2'b11,2'b11,2'b10,2'b10,1'b0,1'b0,N,N,64'h0000_0200_0000_0000,Z,Z};
        tv[18] = '{2'b00,2'b01,2'b00,2'b11,2'b01,ACC,N,N,32'h200,N,N,32'hCCCC,D, 2'b11,2'b10,2'b10,2'b10,1'b0,1'b0,N,N,64'h0000_0200_0000_0000,Z,64'h0000_0000_0000_CCCC};
        tv[19] = '{2'b00,2'b01,2'b00,2'b11,2'b01,ACC,N,N,32'h200,N,N,32'hDDDD,D, 2'b11,2'b10,2'b10,2'b10,1'b0,1'b0,N,N,64'h0000_0200_0000_0000,Z,64'h0000_0000_0000_DDDD};
        tv[20] = '{2'b00,2'b00,2'b00,2'b00,2'b00,ACC,N,N,N,N,N,N,D, 2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,N,N,Z,Z,Z};
        // S->M upgrade from CPU1: single snoop cycle, no data movement
        tv[21] = '{2'b00,2'b00,2'b00,2'b10,2'b10,ACC,N,N,N,32'h600,N,N,D, 2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,N,N,Z,Z,Z};
        tv[22] = '{2'b00,2'b00,2'b00,2'b10,2'b10,ACC,N,N,N,32'h600,N,N,D, 2'b11,2'b11,2'b01,2'b01,1'b0,1'b0,N,N,64'h600,Z,Z};
        tv[23] = '{2'b00,2'b00,2'b00,2'b00,2'b00,ACC,N,N,N,N,N,N,D, 2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,N,N,Z,Z,Z};
        // simultaneous evictions alternate, both ahead of pending ifetches
        tv[24] = '{2'b11,2'b00,2'b11,2'b00,2'b00,ACC,32'h40,32'h80,32'h700,32'h800,32'hE0E0,32'hE1E1,D, 2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,N,N,Z,Z,Z};
        tv[25] = '{2'b11,2'b00,2'b11,2'b00,2'b00,BSY,32'h40,32'h80,32'h700,32'h800,32'hE0E0,32'hE1E1,D, 2'b11,2'b11,2'b00,2'b00,1'b0,1'b1,32'h700,32'hE0E0,Z,Z,Z};
        tv[26] = '{2'b11,2'b00,2'b11,2'b00,2'b00,ACC,32'h40,32'h80,32'h700,32'h800,32'hE0E0,32'hE1E1,D, 2'b11,2'b10,2'b00,2'b00,1'b0,1'b1,32'h700,32'hE0E0,Z,Z,Z};
        tv[27] = '{2'b11,2'b00,2'b11,2'b00,2'b00,ACC,32'h40,32'h80,32'h700,32'h800,32'hE0E0,32'hE1E1,D, 2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,N,N,Z,Z,Z};
        tv[28] = '{2'b11,2'b00,2'b11,2'b00,2'b00,ACC,32'h40,32'h80,32'h700,32'h800,32'hE0E0,32'hE1E1,D, 2'b11,2'b01,2'b00,2'b00,1'b0,1'b1,32'h800,32'hE1E1,Z,Z,Z};
        tv[29] = '{2'b11,2'b00,2'b00,2'b00,2'b00,ACC,32'h40,32'h80,N,N,N,N,D, 2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,N,N,Z,Z,Z};
        tv[30] = '{2'b11,2'b00,2'b00,2'b00,2'b00,ACC,32'h40,32'h80,N,N,N,N,32'h55550040, 2'b10,2'b11,2'b00,2'b00,1'b1,1'b0,32'h40,N,Z,64'h0000_0000_5555_0040,Z};
        tv[31] = '{2'b00,2'b00,2'b00,2'b00,2'b00,ACC,N,N,N,N,N,N,D, 2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,N,N,Z,Z,Z};
        clr();
        nRST = 1'b0;
        iREN = 2'b11; dWEN = 2'b11; cctrans = 2'b11; ramstate = ACC; ramload = D;
        repeat (2) @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("rst_iwait", 64'(iwait), 64'(2'b11));
        chk("rst_dwait", 64'(dwait), 64'(2'b11));
        chk("rst_ccwait", 64'(ccwait), 64'(2'b00));
        chk("rst_ram", 64'({ramREN, ramWEN, ramaddr, ramstore}), 64'h0);
        chk("rst_loads", iload | dload | ccsnoopaddr, Z);
        tick();
        nRST = 1'b1;
        for (int k = 0; k < 32; k++) begin
            apply(tv[k]);
            @(negedge CLK);
            check_row(k, tv[k]);
            tick();
        end
        // snoop miss: two RAM reads with BUSY stalls, dwait low one cycle per word
        clr();
        cctrans = 2'b10; dREN = 2'b10; daddr = {32'h300, N}; ramstate = BSY;
        @(negedge CLK);
        chk("miss_idle_ccwait", 64'(ccwait), 64'(2'b00));
        tick();
        @(negedge CLK);
        chk("miss_snoop_ccwait", 64'(ccwait), 64'(2'b01));
        chk("miss_snoop_addr", ccsnoopaddr, 64'h300);
        tick();
        for (int w = 0; w < 2; w++) begin
            daddr = {32'h300 + 32'(4 * w), N};
            ramstate = BSY;
            for (int c = 0; c < 3; c++) begin
                @(negedge CLK);
                chk($sformatf("miss_w%0d_busy%0d_dwait", w, c), 64'(dwait), 64'(2'b11));
                chk($sformatf("miss_w%0d_busy%0d_addr", w, c), 64'({ramREN, ramaddr}), {31'h0, 1'b1, 32'h300 + 32'(4 * w)});
                tick();
            end
            ramstate = ACC;
            ramload = 32'h7000_0000 + 32'(w);
            @(negedge CLK);
            chk($sformatf("miss_w%0d_dwait", w), 64'(dwait), 64'(2'b01));
            chk($sformatf("miss_w%0d_dload", w), dload, {32'h7000_0000 + 32'(w), N});
            tick();
        end
        clr();
        @(negedge CLK);
        chk("miss_done_ramREN", 64'(ramREN), 64'h0);
        chk("miss_done_dwait", 64'(dwait), 64'(2'b11));
        tick();
        // reset while a RAM read is stalled
        cctrans = 2'b01; dREN = 2'b01; daddr = {N, 32'h900}; ramstate = BSY;
        tick();
        tick();
        @(negedge CLK);
        chk("rstmid_rd_active", 64'({ramREN, ramaddr}), {31'h0, 1'b1, 32'h900});
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        @(negedge CLK);
        chk("rstmid_dwait", 64'(dwait), 64'(2'b11));
        chk("rstmid_ramREN", 64'(ramREN), 64'h0);
        chk("rstmid_ccwait", 64'(ccwait), 64'(2'b00));
        chk("rstmid_dload", dload, Z);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
